// File: rtl/alu_pipe_if.sv
// alu_pipe_if: issue-side request and writeback-side result handshake bundle for alu_pipe
interface alu_pipe_if #(
    parameter int DATAPATH_WIDTH = 64,
    parameter int TAG_WIDTH      = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DATAPATH_WIDTH-1:0] a_in;
    logic [DATAPATH_WIDTH-1:0] b_in;
    logic [3:0]                alu_ctrl_in;
    logic [TAG_WIDTH-1:0]      tag_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATAPATH_WIDTH-1:0] accum_out;
    logic [TAG_WIDTH-1:0]      tag_out;
    logic                      flag_zero;
    logic                      flag_neg;
    logic                      flag_carry;
    logic                      flag_ovf;
    logic                      illegal_out;
    modport master (
        output in_valid, a_in, b_in, alu_ctrl_in, tag_in, out_ready,
        input  in_ready, out_valid, accum_out, tag_out,
               flag_zero, flag_neg, flag_carry, flag_ovf, illegal_out
    );
    modport slave (
        input  in_valid, a_in, b_in, alu_ctrl_in, tag_in, out_ready,
        output in_ready, out_valid, accum_out, tag_out,
               flag_zero, flag_neg, flag_carry, flag_ovf, illegal_out
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered, handshaked ALU with flags, tag passthrough and an iterative shift-add multiplier
module alu_pipe #(
    parameter int DATAPATH_WIDTH = 64,
    parameter int SHAMT_WIDTH    = 6,
    parameter int TAG_WIDTH      = 4
) (
    input logic       clk,
    input logic       reset,
    alu_pipe_if.slave bus
);
    localparam int W = DATAPATH_WIDTH;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
        OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7, OP_SLT = 4'd8,
        OP_SLTU = 4'd9, OP_NOR = 4'd10, OP_PASSB = 4'd11, OP_MUL = 4'd12;
    typedef enum logic {IDLE, MUL} state_t;
    state_t                 state_q, state_d;
    logic                   out_valid_q, out_valid_d;
    logic [W-1:0]           accum_q, accum_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic                   zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;
    logic                   ovf_q, ovf_d, ill_q, ill_d;
    logic [2*W-1:0]         mcand_q, mcand_d, prod_q, prod_d;
    logic [W-1:0]           mplier_q, mplier_d;
    logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
    logic [TAG_WIDTH-1:0]   mtag_q, mtag_d;
    logic                   accept, pop, mul_done;
    logic [W-1:0]           a, b, res, diff;
    logic [W:0]             sum;
    logic                   res_c, res_v;
    logic [SHAMT_WIDTH-1:0] sh;
    logic [3:0]             op;
    logic [2*W-1:0]         prod_nxt;
    assign a        = bus.a_in;
    assign b        = bus.b_in;
    assign op       = bus.alu_ctrl_in;
    assign sh       = b[SHAMT_WIDTH-1:0];
    assign bus.in_ready = !reset && state_q == IDLE && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && bus.in_ready;
    assign pop      = out_valid_q && bus.out_ready;
    assign mul_done = state_q == MUL && cnt_q == SHAMT_WIDTH'(W - 1);
    assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = a - b;
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[W-1:0];
                res_c = sum[W];
                res_v = a[W-1] == b[W-1] && sum[W-1] != a[W-1];
            end
            OP_SUB: begin
                res   = diff;
                res_c = a < b;
                res_v = a[W-1] != b[W-1] && diff[W-1] != a[W-1];
            end
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_SLL:   res = a << sh;
            OP_SRL:   res = a >> sh;
            OP_SRA:   res = $signed(a) >>> sh;
            OP_SLT:   res = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:  res = {{(W-1){1'b0}}, a < b};
            OP_NOR:   res = ~(a | b);
            OP_PASSB: res = b;
            default:  res = '0;
        endcase
    end
    always_comb begin
        state_d     = state_q;
        out_valid_d = pop ? 1'b0 : out_valid_q;
        accum_d     = accum_q;
        tag_d       = tag_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        ill_d       = ill_q;
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        mtag_d      = mtag_q;
        if (accept && op == OP_MUL) begin
            state_d  = MUL;
            mcand_d  = {{W{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = '0;
            mtag_d   = bus.tag_in;
        end else if (accept) begin
            out_valid_d = 1'b1;
            accum_d     = res;
            tag_d       = bus.tag_in;
            zero_d      = res == '0;
            neg_d       = res[W-1];
            carry_d     = res_c;
            ovf_d       = res_v;
            ill_d       = op > OP_MUL;
        end
        if (state_q == MUL) begin
            prod_d   = prod_nxt;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SHAMT_WIDTH'(1);
        end
        // Acceptance required an empty or popping output register, so completion never stalls.
        if (mul_done) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            accum_d     = prod_nxt[W-1:0];
            tag_d       = mtag_q;
            zero_d      = prod_nxt[W-1:0] == '0;
            neg_d       = prod_nxt[W-1];
            carry_d     = |prod_nxt[2*W-1:W];
            ovf_d       = 1'b0;
            ill_d       = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            accum_q     <= '0;
            tag_q       <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
            mcand_q     <= '0;
            prod_q      <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            mtag_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            accum_q     <= accum_d;
            tag_q       <= tag_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            ill_q       <= ill_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            mtag_q      <= mtag_d;
        end
    end
    assign bus.out_valid   = out_valid_q;
    assign bus.accum_out   = accum_q;
    assign bus.tag_out     = tag_q;
    assign bus.flag_zero   = zero_q;
    assign bus.flag_neg    = neg_q;
    assign bus.flag_carry  = carry_q;
    assign bus.flag_ovf    = ovf_q;
    assign bus.illegal_out = ill_q;
endmodule
